// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-2 Booth controller for a signed 64x64 -> 128 multiply.
// Owns the IDLE/RUN/DONE state machine, the iteration counter and the
// A/Q/Q-1 working registers. The add/subtract step uses the ones-complement
// plus carry-in form: operand XOR sub, carry-in = sub.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous, active-high reset
//   start        : request, accepted on a rising edge while ready=1
//   abort        : cancels an operation in RUN (no done, product unchanged)
//   multiplicand : signed M, sampled on the accept edge only
//   multiplier   : signed Q, sampled on the accept edge only
//   ready        : high in IDLE and DONE
//   busy         : high in RUN
//   done         : one-cycle pulse, product valid
//   product      : signed M*Q, held until the next done
//
// Optional feature macro: BOOTH_ZERO_SKIP_EN
//   When defined, a zero operand bypasses RUN; done follows one cycle
//   after the accept edge with product=0 and busy never asserts.
// -----------------------------------------------------------------------------
module booth_mult_seq (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic signed [63:0]   multiplicand,
    input  logic signed [63:0]   multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic signed [127:0]  product
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2
`ifdef BOOTH_ZERO_SKIP_EN
        ,
        ZSKIP = 2'd3
`endif
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic signed [64:0] m_p0;      // sign-extended multiplicand
    logic signed [64:0] a_p0;      // accumulator, one guard bit for M=-2^63
    logic        [63:0] q_p0;
    logic               q_m1_p0;
    logic        [5:0]  count;

    logic               accept;
    logic               last_iter;
    logic signed [64:0] a_sum;
    logic signed [64:0] a_shift;
    logic        [63:0] q_shift;

    // One Booth add/subtract step. sel = {Q[0], Q-1}.
    function automatic logic signed [64:0] booth_step(
        input logic signed [64:0] acc,
        input logic signed [64:0] mcand,
        input logic        [1:0]  sel
    );
        logic        sub;
        logic        en;
        logic [64:0] opnd;
        sub  = (sel == 2'b10);
        en   = sel[1] ^ sel[0];
        opnd = en ? (mcand ^ {65{sub}}) : 65'd0;
        return $signed(acc + opnd + {64'd0, sub});
    endfunction

    assign accept    = start & ready;
    assign last_iter = (count == 6'd63);

    assign a_sum   = booth_step(a_p0, m_p0, {q_p0[0], q_m1_p0});
    // Arithmetic right shift of {A,Q,Q-1}; A[64] is replicated.
    assign a_shift = {a_sum[64], a_sum[64:1]};
    assign q_shift = {a_sum[0], q_p0[63:1]};

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
`ifdef BOOTH_ZERO_SKIP_EN
                    if ((multiplicand == 64'sd0) || (multiplier == 64'sd0))
                        state_nxt = ZSKIP;
                    else
                        state_nxt = RUN;
`else
                    state_nxt = RUN;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (abort)
                    state_nxt = IDLE;
                else if (last_iter)
                    state_nxt = DONE;
            end
`ifdef BOOTH_ZERO_SKIP_EN
            ZSKIP: state_nxt = DONE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            m_p0    <= '0;
            a_p0    <= '0;
            q_p0    <= '0;
            q_m1_p0 <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                m_p0    <= {multiplicand[63], multiplicand};
                q_p0    <= multiplier;
                a_p0    <= '0;
                q_m1_p0 <= 1'b0;
                count   <= '0;
            end else if ((state == RUN) && !abort) begin
                a_p0    <= a_shift;
                q_p0    <= q_shift;
                q_m1_p0 <= q_p0[0];
                count   <= count + 6'd1;
                if (last_iter)
                    product <= {a_shift[63:0], q_shift};
            end
`ifdef BOOTH_ZERO_SKIP_EN
            if (state == ZSKIP)
                product <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic signed [63:0]  multiplicand = '0;
    logic signed [63:0]  multiplier = '0;
    logic                ready;
    logic                busy;
    logic                done;
    logic signed [127:0] product;

    booth_mult_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .ready(ready), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nfail = 0;

    typedef struct {
        logic [127:0] prod;
        int           cyc;
    } exp_t;
    exp_t sb[$];

`ifdef BOOTH_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 64;
`endif

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h required %h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_done: got done with product %h required no done (cyc %0d)", product, cyc);
            end else begin
                e = sb.pop_front();
                chk("product", product, e.prod);
                chk("done_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    task automatic scramble();
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
    endtask

    // Drive one request. When now=1 the request is driven in the current
    // low phase, otherwise at the next falling edge. Returns the accept edge.
    task automatic issue(input logic [63:0] mc, input logic [63:0] mp,
                         input logic [127:0] ex, input int lat, input bit push,
                         input bit now, output int e_edge);
        if (!now) @(negedge clk);
        multiplicand = mc;
        multiplier   = mp;
        start        = 1'b1;
        e_edge       = cyc + 1;
        if (push) sb.push_back('{ex, e_edge + lat});
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input string nm, input int budget, output int busy_n);
        bit got;
        busy_n = 0;
        got    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
        if (!got) begin
            nchk++;
            nfail++;
            $display("FAIL %s_timeout: got no done in %0d cycles required done", nm, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish by 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2, bn;

        // Reset state
        scramble();
        #12;
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_product", product, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // 3 x 5: latency and busy width
        issue(64'd3, 64'd5, 128'd15, 64, 1, 0, e);
        wait_done("3x5", 200, bn);
        chk("busy_cycles", 128'(bn), 128'd64);
        chk("ready_in_done", 128'(ready), 128'd1);

        // Signed and boundary operands
        issue(-64'sd7, 64'd6, -128'sd42, 64, 1, 0, e);
        wait_done("m7x6", 200, bn);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              128'h4000_0000_0000_0000_0000_0000_0000_0000, 64, 1, 0, e);
        wait_done("minxmin", 200, bn);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
              128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 64, 1, 0, e);
        wait_done("maxxmax", 200, bn);
        issue(64'h8000_0000_0000_0000, -64'sd1,
              128'h0000_0000_0000_0000_8000_0000_0000_0000, 64, 1, 0, e);
        wait_done("minxm1", 200, bn);
        issue(64'h8000_0000_0000_0000, 64'd1,
              128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 64, 1, 0, e);
        wait_done("minx1", 200, bn);

        // Start during RUN ignored, then back-to-back start in DONE
        issue(64'd100, -64'sd3, -128'sd300, 64, 1, 0, e);
        while (cyc < e + 9) @(negedge clk);
        multiplicand = 64'd77;
        multiplier   = 64'd77;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_midrun_start", 128'(busy), 128'd1);
        wait_done("ign_start", 200, bn);
        issue(64'd12345, -64'sd2, -128'sd24690, 64, 1, 1, e2);
        chk("b2b_accept_edge", 128'(e2), 128'(e + 65));
        wait_done("b2b", 200, bn);
        @(negedge clk);

        // Abort in RUN: no done, product kept
        issue(64'd9, 64'd9, 128'd81, 64, 0, 0, e);
        while (cyc < e + 20) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_ready", 128'(ready), 128'd1);
        repeat (80) @(negedge clk);
        chk("abort_product_kept", product, -128'sd24690);

        // abort+start together in IDLE is accepted
        abort = 1'b1;
        issue(64'd2, 64'd3, 128'd6, 64, 1, 0, e);
        abort = 1'b0;
        wait_done("abort_start_idle", 200, bn);

        // Asynchronous reset mid-RUN
        issue(64'd5, 64'd5, 128'd25, 64, 0, 0, e);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_ready", 128'(ready), 128'd1);
        chk("midrst_product", product, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(64'd11, -64'sd11, -128'sd121, 64, 1, 0, e);
        wait_done("after_rst", 200, bn);

        // Zero operands
        issue(64'd0, 64'd12345, 128'd0, ZLAT, 1, 0, e);
        wait_done("zero_mc", 200, bn);
        chk("zero_busy_cycles", 128'(bn), 128'(ZLAT == 1 ? 0 : 64));
        issue(-64'sd5, 64'd0, 128'd0, ZLAT, 1, 0, e);
        wait_done("zero_mp", 200, bn);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Sequential radix-2 Booth controller for the signed 64x64 multiplier. It owns the state machine, the iteration counter, and the A/Q/Q-1 working registers. Each cycle it drives the add/subtract step using the ones-complement-plus-carry-in scheme: operand XORed with `sub`, carry-in = `sub`. It sits between the requesting logic and the 128-bit product consumer, with a start/ready/done handshake.

## Interface
- No parameters; width fixed at 64-bit operands, 128-bit product.
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  request; accepted on a rising edge when `ready`=1.
- `abort`  input  1  cancels an operation in RUN.
- `multiplicand`  input  64  signed M; sampled on the accept edge only.
- `multiplier`  input  64  signed Q; sampled on the accept edge only.
- `ready`  output  1  high in IDLE and DONE.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle pulse; `product` is valid.
- `product`  output  128  signed M*Q; held until the next `done`.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `product`=0, `done`=0, `busy`=0, `ready`=1, count=0, A=0, Q-1=0.
- Accept (`start` & `ready`):
  - M is loaded sign-extended to 65 bits.
  - Q=`multiplier`, A=0 (65 bits), Q-1=0, count=0.
  - Next state is RUN.
- Each RUN cycle, selected by {Q[0],Q-1}:
  - 01: A=A+M.
  - 10: A=A+~M+1 (sub=1).
  - 00/11: A unchanged.
  - Then {A,Q,Q-1} arithmetic-shifts right one bit, with A[64] replicated; count increments.
- A is 65 bits so that subtracting M=-2^63 does not overflow.
- When count reaches 63, that iteration completes and the next state is DONE.
  - `product` is loaded with {A[63:0],Q}.
- DONE lasts one cycle with `done`=1, then returns to IDLE.
  - If `start` is high in DONE, the new operands are accepted and the next state is RUN (back-to-back).
- `abort` in RUN: next state is IDLE, no `done`, `product` unchanged.
- `abort` in IDLE or DONE is ignored; `start` still takes effect.
- `start` in RUN is ignored. Operands are not re-sampled.
- Asynchronous `rst` at any time forces the reset values immediately; the in-flight operation is lost.

## Timing
- Accept at edge E. Iterations occur on edges E+1 … E+64.
- `done` is high from E+64 to E+65. Latency is 64 cycles from the accept edge.
- `product` changes only at the edge that enters DONE.
- `busy` is high from E to E+64, exactly 64 cycles.
- Back-to-back throughput: one result per 65 cycles.
- `ready` is combinational from state; no combinational path from inputs to outputs.

## Configuration
- `BOOTH_ZERO_SKIP_EN`, when defined:
  - On accept, if `multiplicand`==0 or `multiplier`==0, the next state is DONE directly, skipping RUN.
  - `product`=0, and `done` asserts at E+1 to E+2, i.e. latency 1.
  - `busy` stays 0 for that operation.
- When undefined: zero operands take the full 64-cycle RUN path with identical timing to any other operands.

## Test plan
- 3 × 5, start at edge E → `done` at E+64, `product`=15, `busy` high for exactly 64 cycles.
- -7 × 6 → `product`=128'hFFFF…FFD6 (-42). Then 0x8000_0000_0000_0000 × 0x8000_0000_0000_0000 → `product`=2^126 (bit 126 only).
- Pulse `start` with new operands at E+10 during RUN → ignored; the result is that of the original operands at E+64. Start asserted in the DONE cycle → second `done` at E+129 with the second result.
- `abort` at E+20 → IDLE at E+21, no `done`, `product` keeps its prior value. An `abort`+`start` pair in IDLE is accepted normally.
- Assert `rst` mid-RUN, between edges → `busy`=0, `ready`=1, `product`=0 immediately. A new start afterwards completes correctly.
- 0 × 12345 with `BOOTH_ZERO_SKIP_EN` → `done` at E+1, `product`=0. Without the macro → `done` at E+64, `product`=0.
